mdu: RTL and testbench
======================

# mdu

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, the sequential companion to the single-cycle ALU in the execute stage of the MIPS datapath. It accepts signed/unsigned multiply and divide plus direct HI/LO writes, holds `busy` for a fixed, parameterised number of cycles, then commits the result to HI/LO. The hazard unit stalls any HI/LO-dependent instruction while `start || busy`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `MUL_CYCLES`, default 5: busy cycles for `mult` and `multu`, ≥1.
- `DIV_CYCLES`, default 10: busy cycles for `div` and `divu`, ≥1.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-high.
- `start  in  1`: launch the op on `mdu_op` this cycle.
- `mdu_op  in  3`: 0 `mult`, 1 `multu`, 2 `div`, 3 `divu`, 4 `mthi`, 5 `mtlo`; 6–7 no-op.
- `a  in  WIDTH`: rs operand (dividend / multiplicand / mt data).
- `b  in  WIDTH`: rt operand (divisor / multiplier).
- `busy  out  1`: registered; high while an op is in flight.
- `hi  out  WIDTH`: HI register, read directly by `mfhi`.
- `lo  out  WIDTH`: LO register, read directly by `mflo`.

## Operation
- **Reset values:** `busy`=0, `hi`=0, `lo`=0, counter=0, pending result=0.
- **States:** IDLE and RUN.
  - IDLE → RUN on `start` with `mdu_op` in 0–3. Latch the full result into pending HI/LO, load counter with `MUL_CYCLES` or `DIV_CYCLES`, set `busy`.
  - In RUN the counter decrements each cycle. At count 1, commit pending → `hi`/`lo`, clear `busy`, return to IDLE.
- **`mthi` / `mtlo` in IDLE:** write `a` to `hi` / `lo` at the next edge. `busy` stays 0.
- **Ignored inputs:**
  - `start` while `busy`: ignored, no state change. Upstream must stall, so this is a protocol violation that is tolerated without effect.
  - `mdu_op` 6–7 with `start`: no effect.
- **Multiply:**
  - Product width is 2·WIDTH. HI = upper WIDTH bits, LO = lower WIDTH bits.
  - `mult` sign-extends both operands. `multu` zero-extends both operands.
- **Divide:** LO = quotient truncated toward zero; HI = remainder, which carries the sign of the dividend (`div`). `divu` is unsigned.
- **Divide by zero (both div ops):** LO = all ones, HI = `a`.
- **`div` of INT_MIN by −1:** LO = INT_MIN, HI = 0.
- **HI/LO visibility:** `hi`/`lo` hold their old values for the whole RUN period. A new value is visible only from the cycle after `busy` falls.
- **Reset mid-RUN:** aborts the op. The pending result is discarded and never commits; all outputs go to reset values.

## Timing
- `start` sampled at edge E0 gives `busy`=1 from E0 through edge E0+N−1, where N is the op's cycle count.
- At edge E0+N, `busy`=0 and `hi`/`lo` hold the new values in the same cycle.
- N=1 gives one busy cycle.
- Back-to-back: a new `start` is accepted in the first cycle `busy`=0.
- `mthi`/`mtlo` have one-cycle latency and are never busy.
- `busy` never depends combinationally on `start`. The hazard unit ORs them itself.

## Structure
- **Shared package `mdu_pkg`:**
  - op encodings `MDU_MULT`…`MDU_MTLO`;
  - state encoding `MDU_IDLE`/`MDU_RUN`;
  - default `WIDTH`, `MUL_CYCLES`, `DIV_CYCLES` constants.
- **Sub-module `mdu_arith`:** combinational, WIDTH-parameterised. It produces the {HI,LO} result for ops 0–3, including the div-by-zero and overflow cases.
- **Top `mdu`:** owns the FSM, the counter, the pending registers and HI/LO.

## Test plan
- **`mult`:** a=0xFFFFFFFD, b=7 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. With `multu` on the same inputs: HI=0x00000006, LO=0xFFFFFFEB.
- **`div`:** a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. With `divu` a=7, b=2: LO=3, HI=1.
- **Edge cases:**
  - `div` a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678.
  - `div` a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Ignored `start` while busy:** `mult` 3×4, then `start` `mtlo` a=0xAA on busy cycle 2 → ignored. Final HI=0, LO=12 at cycle 5; HI/LO unchanged during busy.
- **IDLE moves:** `mthi` a=0x55 → HI=0x55 next cycle, `busy` stays 0. A following `mflo`-style read observes the old LO.
- **Reset mid-RUN:** `reset` on busy cycle 3 of `divu` 100/7 → next cycle `busy`=0, HI=LO=0, and no commit appears in later cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and default sizing constants.
package mdu_pkg;

    localparam int MDU_WIDTH      = 32;
    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    // mdu_op encodings; 6 and 7 are no-ops.
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational {HI,LO} result for mult/multu/div/divu, including the
// divide-by-zero and INT_MIN / -1 corner cases.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               is_mul;
    logic               sgn_mul;
    logic               sgn_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Multiply: extend both operands to 2*WIDTH (sign or zero), the low
    // 2*WIDTH bits of the product are then correct for either signedness.
    // Divide: work on magnitudes, then restore signs; quotient truncates
    // toward zero and the remainder follows the dividend. INT_MIN / -1
    // falls out naturally as magnitude 2^(WIDTH-1) re-negated to itself.
    always_comb begin
        is_mul  = (op == MDU_MULT) || (op == MDU_MULTU);
        sgn_mul = (op == MDU_MULT);
        sgn_div = (op == MDU_DIV);

        a_ext = sgn_mul ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = sgn_mul ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;

        a_neg  = sgn_div & a[WIDTH-1];
        b_neg  = sgn_div & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // Keep the divider away from a zero divisor; that result is overridden.
        b_safe = (b == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        if (is_mul) begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end else if (b == '0) begin
            hi = a;
            lo = '1;
        end else begin
            hi = rem;
            lo = quot;
        end
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is
// computed at launch, held in pending registers for a fixed number of busy
// cycles, then committed to HI/LO.
//
// Handshake: start is taken only in IDLE (busy=0). A start seen while busy
// is dropped without effect; upstream is expected to stall on start||busy.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = MDU_WIDTH,
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    logic             launch;
    logic             commit;
    logic             wr_hi;
    logic             wr_lo;
    logic             is_div;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op (mdu_op),
        .a  (a),
        .b  (b),
        .hi (arith_hi),
        .lo (arith_lo)
    );

    assign is_div = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= MDU_IDLE;
        else       state <= state_next;
    end

    // Next-state and control strobes; mt* and long ops only start from IDLE.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    if (mdu_op <= MDU_DIVU) begin
                        launch     = 1'b1;
                        state_next = MDU_RUN;
                    end else if (mdu_op == MDU_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (mdu_op == MDU_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            MDU_RUN: begin
                if (count == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = MDU_IDLE;
                end
            end
            default: state_next = MDU_IDLE;
        endcase
    end

    // Datapath: latch result at launch, count down, commit to HI/LO at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (launch) begin
                pend_hi <= arith_hi;
                pend_lo <= arith_lo;
                count   <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                busy    <= 1'b1;
            end else if (state == MDU_RUN) begin
                count <= count - CW'(1);
            end
            if (commit) begin
                hi   <= pend_hi;
                lo   <= pend_lo;
                busy <= 1'b0;
            end
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed plus random checks of the multiply/divide unit.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    int          vectors;
    int          errors;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model for the four arithmetic ops, built on 64-bit integers.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        ua = {32'd0, xa};
        ub = {32'd0, xb};
        case (op)
            MDU_MULT:  begin q = sa * sb; return q; end
            MDU_MULTU: begin p = ua * ub; return p; end
            MDU_DIV: begin
                if (xb == 32'd0) return {xa, 32'hFFFF_FFFF};
                if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (xb == 32'd0) return {xa, 32'hFFFF_FFFF};
                p = ua / ub;
                ua = ua % ub;
                return {ua[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Launch a long op, check busy length and HI/LO hold, then compare result.
    // ign_at > 0 drives a stray mtlo start on that busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [63:0] exp_hl, input int ign_at);
        logic [63:0] old_hl;
        logic [63:0] want;
        int          cyc;
        int          n;
        n      = (op == MDU_MULT || op == MDU_MULTU) ? MDU_MUL_CYCLES : MDU_DIV_CYCLES;
        old_hl = {hi, lo};
        exp_q.push_back(exp_hl);
        start  = 1'b1;
        mdu_op = op;
        a      = xa;
        b      = xb;
        #1;
        check("busy_not_comb", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 40) begin
            check("hold_hilo", {hi, lo}, old_hl);
            if (cyc + 1 == ign_at) begin
                start  = 1'b1;
                mdu_op = MDU_MTLO;
                a      = 32'hAA;
            end
            cyc++;
            tick();
            start = 1'b0;
        end
        check("busy_len", 64'(cyc), 64'(n));
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("result", {hi, lo}, want);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] old_lo;
        logic [63:0] old_hl;

        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        mdu_op  = 3'd0;
        a       = '0;
        b       = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // Directed arithmetic, issued back-to-back.
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 0);
        run_op(MDU_MULTU, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB}, 0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_op(MDU_DIVU,  32'd7, 32'd2, {32'd1, 32'd3}, 0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 0);
        run_op(MDU_DIV,   32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0);
        run_op(MDU_DIV,   32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 0);
        run_op(MDU_DIVU,  32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 0);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
        run_op(MDU_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 0);

        // Stray mtlo start on busy cycle 2 must be ignored.
        run_op(MDU_MULT, 32'd3, 32'd4, {32'd0, 32'd12}, 2);

        // mthi in IDLE: one-cycle latency, never busy, LO untouched.
        old_lo = lo;
        exp_q.push_back({32'h55, old_lo});
        start  = 1'b1;
        mdu_op = MDU_MTHI;
        a      = 32'h55;
        tick();
        start = 1'b0;
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_hilo", {hi, lo}, exp_q.pop_front());

        // mtlo in IDLE.
        exp_q.push_back({32'h55, 32'hC0DE});
        start  = 1'b1;
        mdu_op = MDU_MTLO;
        a      = 32'hC0DE;
        tick();
        start = 1'b0;
        check("mtlo_hilo", {hi, lo}, exp_q.pop_front());

        // No-op encodings leave everything alone.
        old_hl = {hi, lo};
        start  = 1'b1;
        mdu_op = 3'd6;
        a      = 32'hDEAD;
        tick();
        mdu_op = 3'd7;
        tick();
        start = 1'b0;
        check("noop_busy", {63'd0, busy}, 64'd0);
        check("noop_hilo", {hi, lo}, old_hl);

        // Random arithmetic against the reference model.
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (rb == 32'd0) rb = 32'd1;
            run_op(rop, ra, rb, model(rop, ra, rb), 0);
        end

        // Reset during busy cycle 3 of divu 100/7 aborts the op.
        start  = 1'b1;
        mdu_op = MDU_DIVU;
        a      = 32'd100;
        b      = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_abort_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_commit", {31'd0, busy, hi, lo} , 64'd0);
        end

        // Unit still usable after the abort.
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'd1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
